// File: rtl/keypad_decimal_to_binary.sv
// keypad_decimal_to_binary
// Collects keypad digits, sign and decimal point, then converts the entered
// decimal number to the calculator's 16-bit fixed-point word
// (sign | 9 integer bits | 6 fraction bits in 1/64 units, two's complement).
// Optional macro FRAC_ROUND_EN: round the fraction to the nearest 1/64
// instead of truncating it.
module keypad_decimal_to_binary (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] binary_out,
    output logic        out_valid,
    output logic        overflow
);

    typedef enum logic [1:0] {ST_INT, ST_FRAC, ST_CONV, ST_DONE} state_t;

    localparam logic [3:0]  KEY_MINUS   = 4'hA;
    localparam logic [3:0]  KEY_POINT   = 4'hB;
    localparam logic [3:0]  KEY_CLEAR   = 4'hC;
    localparam logic [3:0]  KEY_ENTER   = 4'hD;
    localparam logic [11:0] DIV_START   = 12'd3200;
    localparam logic [2:0]  LAST_STEP   = 3'd5;

`ifdef FRAC_ROUND_EN
    localparam logic [12:0] ROUND_BIAS = 13'd50;
`else
    localparam logic [12:0] ROUND_BIAS = 13'd0;
`endif

    state_t      r_state;
    state_t      w_nextState;

    logic [9:0]  r_intAcc;
    logic [1:0]  r_intCnt;
    logic [6:0]  r_fracAcc;
    logic [1:0]  r_fracCnt;
    logic        r_neg;

    logic [12:0] r_rem;
    logic [11:0] r_divisor;
    logic [5:0]  r_quot;
    logic [2:0]  r_convCnt;

    logic        w_entry;
    logic        w_accept;
    logic        w_isDigit;
    logic [12:0] w_dividend;
    logic [12:0] w_trial;
    logic        w_trialOk;
    logic        w_intOvf;
    logic [14:0] w_mag;
    logic [15:0] w_result;

    assign w_entry    = (r_state == ST_INT) || (r_state == ST_FRAC);
    assign key_ready  = w_entry;
    assign w_accept   = key_valid && w_entry;
    assign w_isDigit  = (key_code <= 4'd9);
    assign w_dividend = {r_fracAcc, 6'd0} + ROUND_BIAS;
    assign w_trialOk  = (r_rem >= {1'b0, r_divisor});
    assign w_trial    = r_rem - {1'b0, r_divisor};
    assign w_intOvf   = (r_intAcc > 10'd511);
    assign w_mag      = w_intOvf ? 15'h7FFF : {r_intAcc[8:0], r_quot};
    assign w_result   = (r_neg && (w_mag != 15'd0)) ? (16'd0 - {1'b0, w_mag})
                                                    : {1'b0, w_mag};

    // State register; reset drops any conversion in flight back to integer entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: point moves to fraction entry, enter starts the divide,
    // clear returns to integer entry, DONE always lasts exactly one cycle
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_INT: begin
                if (w_accept) begin
                    if (key_code == KEY_POINT) begin
                        w_nextState = ST_FRAC;
                    end else if (key_code == KEY_ENTER) begin
                        w_nextState = ST_CONV;
                    end
                end
            end
            ST_FRAC: begin
                if (w_accept) begin
                    if (key_code == KEY_ENTER) begin
                        w_nextState = ST_CONV;
                    end else if (key_code == KEY_CLEAR) begin
                        w_nextState = ST_INT;
                    end
                end
            end
            ST_CONV: begin
                if (r_convCnt == LAST_STEP) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_INT;
            end
            default: begin
                w_nextState = ST_INT;
            end
        endcase
    end

    // Entry accumulators, 6-step restoring divide by 100, and the registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_intAcc   <= 10'd0;
            r_intCnt   <= 2'd0;
            r_fracAcc  <= 7'd0;
            r_fracCnt  <= 2'd0;
            r_neg      <= 1'b0;
            r_rem      <= 13'd0;
            r_divisor  <= 12'd0;
            r_quot     <= 6'd0;
            r_convCnt  <= 3'd0;
            binary_out <= 16'h0000;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_INT, ST_FRAC: begin
                    if (w_accept) begin
                        if (w_isDigit) begin
                            if (r_state == ST_INT) begin
                                if (r_intCnt < 2'd3) begin
                                    r_intAcc <= r_intAcc * 10'd10 + {6'd0, key_code};
                                    r_intCnt <= r_intCnt + 2'd1;
                                end
                            end else begin
                                if (r_fracCnt == 2'd0) begin
                                    r_fracAcc <= {3'd0, key_code} * 7'd10;
                                    r_fracCnt <= 2'd1;
                                end else if (r_fracCnt == 2'd1) begin
                                    r_fracAcc <= r_fracAcc + {3'd0, key_code};
                                    r_fracCnt <= 2'd2;
                                end
                            end
                        end else if (key_code == KEY_MINUS) begin
                            r_neg <= ~r_neg;
                        end else if (key_code == KEY_CLEAR) begin
                            r_intAcc  <= 10'd0;
                            r_intCnt  <= 2'd0;
                            r_fracAcc <= 7'd0;
                            r_fracCnt <= 2'd0;
                            r_neg     <= 1'b0;
                        end else if (key_code == KEY_ENTER) begin
                            overflow  <= 1'b0;
                            r_rem     <= w_dividend;
                            r_divisor <= DIV_START;
                            r_quot    <= 6'd0;
                            r_convCnt <= 3'd0;
                        end
                    end
                end
                ST_CONV: begin
                    if (w_trialOk) begin
                        r_rem <= w_trial;
                    end
                    r_quot    <= {r_quot[4:0], w_trialOk};
                    r_divisor <= r_divisor >> 1;
                    r_convCnt <= r_convCnt + 3'd1;
                end
                ST_DONE: begin
                    binary_out <= w_result;
                    overflow   <= w_intOvf;
                    out_valid  <= 1'b1;
                    r_intAcc   <= 10'd0;
                    r_intCnt   <= 2'd0;
                    r_fracAcc  <= 7'd0;
                    r_fracCnt  <= 2'd0;
                    r_neg      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
